// File: rtl/spram_arb.sv
// spram_arb: two-requester round-robin arbiter in front of the shared
// single-port SPRAM bus (16-bit, 64K-word, 4-bank cascade, registered read).
// Requester A is the eForth core data port, requester B the loader/debug DMA.
// One command per cycle is forwarded to the memory. Each granted read is
// tagged with its owner so that the one-cycle-late data returns to the right
// requester together with a single-cycle valid pulse.
//
// Optional feature macro: SPRAM_ARB_LOCK_EN
//   Defined   : a requester may hold the bus for up to MAX_LOCK consecutive
//               grants by keeping x_req and x_lock high.
//   Undefined : x_lock inputs are ignored; arbitration is pure round-robin.

module spram_arb #(
    parameter int ASZ      = 17,
    parameter int DSZ      = 16,
    parameter int MSZ      = 4,
    parameter int MAX_LOCK = 8
) (
    input  logic           clk,
    input  logic           rst_n,

    input  logic           a_req,
    input  logic           a_we,
    input  logic [ASZ-1:0] a_ai,
    input  logic [DSZ-1:0] a_vi,
    input  logic [MSZ-1:0] a_bmsk,
    input  logic           a_lock,
    output logic           a_gnt,
    output logic           a_rvld,
    output logic [DSZ-1:0] a_vo,

    input  logic           b_req,
    input  logic           b_we,
    input  logic [ASZ-1:0] b_ai,
    input  logic [DSZ-1:0] b_vi,
    input  logic [MSZ-1:0] b_bmsk,
    input  logic           b_lock,
    output logic           b_gnt,
    output logic           b_rvld,
    output logic [DSZ-1:0] b_vo,

    output logic           m_we,
    output logic [ASZ-1:0] m_ai,
    output logic [DSZ-1:0] m_vi,
    output logic [MSZ-1:0] m_bmsk,
    input  logic [DSZ-1:0] m_vo
);

    typedef enum logic {
        OWN_A = 1'b0,
        OWN_B = 1'b1
    } owner_t;

    // Requester that won the most recent grant; the other one wins a tie.
    owner_t last_owner;

    // Combinational grant decision for the current cycle.
    logic   gnt_a;
    logic   gnt_b;
    logic   gnt_any;
    owner_t gnt_own;

    // One-deep read-return tag: set by a granted read, consumed next cycle.
    logic   pend_vld;
    owner_t pend_own;

`ifdef SPRAM_ARB_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK + 1);

    logic          lock_act;
    owner_t        lock_own;
    logic [CW-1:0] lock_cnt;

    // lock_hold: the lock owner still asks for the bus and still wants the lock.
    logic          lock_hold;
    logic          grant_lock;
    logic [CW-1:0] cnt_next;

    // Decide whether an established lock is still being honoured this cycle.
    always_comb begin
        lock_hold = 1'b0;
        if (lock_act) begin
            if (lock_own == OWN_A) begin
                lock_hold = a_req && a_lock;
            end else begin
                lock_hold = b_req && b_lock;
            end
        end
    end

    // Work out whether this grant is a locked one and what the count becomes.
    always_comb begin
        grant_lock = (gnt_a && a_lock) || (gnt_b && b_lock);
        cnt_next   = '0;
        if (grant_lock) begin
            if (lock_hold) begin
                cnt_next = lock_cnt + 1'b1;
            end else begin
                cnt_next = CW'(1);
            end
        end
    end

    // Lock state: establish, extend, or release (x_lock/x_req drop or MAX_LOCK hit).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_act <= 1'b0;
            lock_own <= OWN_A;
            lock_cnt <= '0;
        end else if (grant_lock && (cnt_next < CW'(MAX_LOCK))) begin
            lock_act <= 1'b1;
            lock_own <= gnt_own;
            lock_cnt <= cnt_next;
        end else begin
            lock_act <= 1'b0;
            lock_cnt <= '0;
        end
    end
`else
    // Lock inputs and MAX_LOCK have no function in the plain round-robin build.
    logic unused_lock;
    assign unused_lock = a_lock | b_lock;
    localparam int unused_max_lock = MAX_LOCK;
`endif

    // Grant selection: honoured lock first, then round-robin on contention.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
`ifdef SPRAM_ARB_LOCK_EN
        if (lock_hold) begin
            if (lock_own == OWN_A) begin
                gnt_a = 1'b1;
            end else begin
                gnt_b = 1'b1;
            end
        end else
`endif
        if (a_req && b_req) begin
            if (last_owner == OWN_B) begin
                gnt_a = 1'b1;
            end else begin
                gnt_b = 1'b1;
            end
        end else begin
            gnt_a = a_req;
            gnt_b = b_req;
        end
    end

    assign gnt_any = gnt_a | gnt_b;
    assign gnt_own = gnt_b ? OWN_B : OWN_A;
    assign a_gnt   = gnt_a;
    assign b_gnt   = gnt_b;

    // Forward the winner's command; an idle cycle becomes an all-zero read.
    always_comb begin
        m_we   = 1'b0;
        m_ai   = '0;
        m_vi   = '0;
        m_bmsk = '0;
        if (gnt_a) begin
            m_we   = a_we;
            m_ai   = a_ai;
            m_vi   = a_vi;
            m_bmsk = a_bmsk;
        end else if (gnt_b) begin
            m_we   = b_we;
            m_ai   = b_ai;
            m_vi   = b_vi;
            m_bmsk = b_bmsk;
        end
    end

    // Remember who won so the other side wins the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= OWN_B;
        end else if (gnt_any) begin
            last_owner <= gnt_own;
        end
    end

    // Tag each granted read so its data returns to the owner one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_vld <= 1'b0;
            pend_own <= OWN_A;
        end else begin
            pend_vld <= gnt_any && !m_we;
            pend_own <= gnt_own;
        end
    end

    assign a_rvld = pend_vld && (pend_own == OWN_A);
    assign b_rvld = pend_vld && (pend_own == OWN_B);

    // Read data is shared; the rvld pulse says who it belongs to.
    assign a_vo = m_vo;
    assign b_vo = m_vo;

endmodule

// File: tb/tb_spram_arb.sv
// tb_spram_arb: directed-vector bench for spram_arb with a behavioural
// SPRAM model (64K x 16, nibble write mask, registered read data).

module tb_spram_arb;

    logic        clk;
    logic        rst_n;

    logic        a_req, a_we, a_lock, a_gnt, a_rvld;
    logic [16:0] a_ai;
    logic [15:0] a_vi, a_vo;
    logic [3:0]  a_bmsk;

    logic        b_req, b_we, b_lock, b_gnt, b_rvld;
    logic [16:0] b_ai;
    logic [15:0] b_vi, b_vo;
    logic [3:0]  b_bmsk;

    logic        m_we;
    logic [16:0] m_ai;
    logic [15:0] m_vi;
    logic [3:0]  m_bmsk;
    logic [15:0] m_vo;

    logic [15:0] mem [0:65535];

    int checkCount;
    int errorCount;

    spram_arb #(
        .ASZ(17), .DSZ(16), .MSZ(4), .MAX_LOCK(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_ai(a_ai), .a_vi(a_vi), .a_bmsk(a_bmsk),
        .a_lock(a_lock), .a_gnt(a_gnt), .a_rvld(a_rvld), .a_vo(a_vo),
        .b_req(b_req), .b_we(b_we), .b_ai(b_ai), .b_vi(b_vi), .b_bmsk(b_bmsk),
        .b_lock(b_lock), .b_gnt(b_gnt), .b_rvld(b_rvld), .b_vo(b_vo),
        .m_we(m_we), .m_ai(m_ai), .m_vi(m_vi), .m_bmsk(m_bmsk), .m_vo(m_vo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SPRAM model: word address is ai[16:1], each bmsk bit guards one nibble.
    always @(posedge clk) begin
        if (m_we) begin
            for (int n = 0; n < 4; n++) begin
                if (m_bmsk[n]) mem[m_ai[16:1]][n*4 +: 4] <= m_vi[n*4 +: 4];
            end
        end else begin
            m_vo <= mem[m_ai[16:1]];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(
        input logic aReq, input logic aWe, input logic [16:0] aAi,
        input logic [15:0] aVi, input logic [3:0] aBmsk, input logic aLock,
        input logic bReq, input logic bWe, input logic [16:0] bAi,
        input logic [15:0] bVi, input logic [3:0] bBmsk, input logic bLock);
        a_req = aReq; a_we = aWe; a_ai = aAi; a_vi = aVi; a_bmsk = aBmsk; a_lock = aLock;
        b_req = bReq; b_we = bWe; b_ai = bAi; b_vi = bVi; b_bmsk = bBmsk; b_lock = bLock;
    endtask

    task automatic applyIdle();
        applyStimulus(0, 0, 17'h0, 16'h0, 4'h0, 0, 0, 0, 17'h0, 16'h0, 4'h0, 0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyIdle();
        rst_n = 1'b0;
        nextCycle();
        nextCycle();
        checkOutput("rst_a_rvld", a_rvld, 0);
        checkOutput("rst_b_rvld", b_rvld, 0);
        checkOutput("rst_m_we", m_we, 0);
        checkOutput("rst_m_ai", m_ai, 0);
        checkOutput("rst_m_bmsk", m_bmsk, 0);
        checkOutput("rst_m_vi", m_vi, 0);
        rst_n = 1'b1;
        nextCycle();
    endtask

    initial begin
        logic expA;
        checkCount = 0;
        errorCount = 0;
        m_vo = 16'h0;
        for (int w = 0; w < 65536; w++) mem[w] = 16'h0;
        mem[17'h00010 >> 1] = 16'h1234;
        mem[17'h00020 >> 1] = 16'hA001;
        mem[17'h00040 >> 1] = 16'hB002;
        rst_n = 1'b1;
        applyIdle();
        #2;
        doReset();

        // Single read by A
        applyStimulus(1, 0, 17'h00010, 16'h0, 4'h0, 0, 0, 0, 17'h0, 16'h0, 4'h0, 0);
        #2;
        checkOutput("t1_a_gnt", a_gnt, 1);
        checkOutput("t1_b_gnt", b_gnt, 0);
        checkOutput("t1_m_ai", m_ai, 17'h00010);
        checkOutput("t1_m_we", m_we, 0);
        nextCycle();
        applyIdle();
        #1;
        checkOutput("t1_a_rvld", a_rvld, 1);
        checkOutput("t1_a_vo", a_vo, 16'h1234);
        checkOutput("t1_b_rvld", b_rvld, 0);
        nextCycle();
        checkOutput("t1_a_rvld_off", a_rvld, 0);

        // Contention: both read for 4 cycles, A wins first after reset
        doReset();
        applyStimulus(1, 0, 17'h00020, 16'h0, 4'h0, 0, 1, 0, 17'h00040, 16'h0, 4'h0, 0);
        for (int i = 0; i < 4; i++) begin
            #2;
            expA = (i % 2 == 0);
            checkOutput("rr_a_gnt", a_gnt, expA);
            checkOutput("rr_b_gnt", b_gnt, !expA);
            if (i > 0) begin
                checkOutput("rr_a_rvld", a_rvld, !expA);
                checkOutput("rr_b_rvld", b_rvld, expA);
                checkOutput("rr_vo", a_vo, expA ? 16'hB002 : 16'hA001);
            end
            nextCycle();
        end
        applyIdle();
        #1;
        checkOutput("rr_last_b_rvld", b_rvld, 1);
        checkOutput("rr_last_a_rvld", a_rvld, 0);
        checkOutput("rr_last_b_vo", b_vo, 16'hB002);
        nextCycle();

        // A writes, B reads the same location next cycle
        applyStimulus(1, 1, 17'h08002, 16'hBEEF, 4'hF, 0, 0, 0, 17'h0, 16'h0, 4'h0, 0);
        #2;
        checkOutput("wr_a_gnt", a_gnt, 1);
        checkOutput("wr_m_we", m_we, 1);
        checkOutput("wr_m_ai", m_ai, 17'h08002);
        checkOutput("wr_m_vi", m_vi, 16'hBEEF);
        checkOutput("wr_m_bmsk", m_bmsk, 4'hF);
        nextCycle();
        applyStimulus(0, 0, 17'h0, 16'h0, 4'h0, 0, 1, 0, 17'h08002, 16'h0, 4'h0, 0);
        #2;
        checkOutput("wr_b_gnt", b_gnt, 1);
        checkOutput("wr_no_a_rvld", a_rvld, 0);
        checkOutput("wr_no_b_rvld", b_rvld, 0);
        nextCycle();
        applyIdle();
        #1;
        checkOutput("rd_b_rvld", b_rvld, 1);
        checkOutput("rd_b_vo", b_vo, 16'hBEEF);
        checkOutput("rd_a_rvld", a_rvld, 0);
        nextCycle();

        // B cancels its request while A holds the bus (last owner is B)
        applyStimulus(1, 0, 17'h00020, 16'h0, 4'h0, 0, 1, 0, 17'h00040, 16'h0, 4'h0, 0);
        #2;
        checkOutput("cx_a_gnt", a_gnt, 1);
        checkOutput("cx_b_gnt", b_gnt, 0);
        checkOutput("cx_m_ai", m_ai, 17'h00020);
        b_req = 1'b0;
        #1;
        checkOutput("cx_b_gnt_drop", b_gnt, 0);
        checkOutput("cx_m_ai_drop", m_ai, 17'h00020);
        nextCycle();
        #2;
        checkOutput("cx_a_gnt2", a_gnt, 1);
        checkOutput("cx_b_gnt2", b_gnt, 0);
        checkOutput("cx_a_rvld", a_rvld, 1);
        checkOutput("cx_b_rvld", b_rvld, 0);
        nextCycle();
        applyIdle();
        #1;
        checkOutput("cx_a_rvld2", a_rvld, 1);
        checkOutput("cx_a_vo", a_vo, 16'hA001);
        checkOutput("cx_b_rvld2", b_rvld, 0);
        nextCycle();
        checkOutput("cx_b_rvld3", b_rvld, 0);

        // Reset while A's read return is pending
        applyStimulus(1, 0, 17'h00010, 16'h0, 4'h0, 0, 0, 0, 17'h0, 16'h0, 4'h0, 0);
        #2;
        checkOutput("mr_a_gnt", a_gnt, 1);
        nextCycle();
        applyIdle();
        rst_n = 1'b0;
        #1;
        checkOutput("mr_a_rvld_rst", a_rvld, 0);
        #1;
        rst_n = 1'b1;
        nextCycle();
        checkOutput("mr_a_rvld", a_rvld, 0);
        checkOutput("mr_b_rvld", b_rvld, 0);
        applyStimulus(1, 0, 17'h00020, 16'h0, 4'h0, 0, 1, 0, 17'h00040, 16'h0, 4'h0, 0);
        #2;
        checkOutput("mr_a_first", a_gnt, 1);
        checkOutput("mr_b_first", b_gnt, 0);
        nextCycle();
        applyIdle();
        nextCycle();

        // A requests with lock held while B waits for 12 cycles
        doReset();
        applyStimulus(1, 0, 17'h00020, 16'h0, 4'h0, 1, 1, 0, 17'h00040, 16'h0, 4'h0, 0);
        for (int i = 0; i < 12; i++) begin
            #2;
`ifdef SPRAM_ARB_LOCK_EN
            expA = (i != 8);
`else
            expA = (i % 2 == 0);
`endif
            checkOutput("lk_a_gnt", a_gnt, expA);
            checkOutput("lk_b_gnt", b_gnt, !expA);
            nextCycle();
        end
        applyIdle();
        nextCycle();
        nextCycle();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
